// File: rtl/cpu_defs.sv
// Shared definitions for the RV32I fetch front end: state codes, NOP word,
// instruction field positions and the default reset vector.
package cpu_defs;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_HOLD  = 2'd1,
        ST_FAULT = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR            = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

    localparam int OPCODE_LSB   = 0;
    localparam int OPCODE_MSB   = 6;
    localparam int FUNCT3_LSB   = 12;
    localparam int FUNCT3_MSB   = 14;
    localparam int FUNCT7B5_BIT = 30;

endpackage

// File: rtl/pc_register.sv
// Program counter with next-PC selection (PC+4 or branch/jump target)
// and a word-alignment check on the selected target.
module pc_register
    import cpu_defs::*;
#(
    parameter int                    ADDR_WIDTH   = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  update,
    input  logic                  PC_select,
    input  logic [ADDR_WIDTH-1:0] PC_target,
    output logic [ADDR_WIDTH-1:0] PC,
    output logic [ADDR_WIDTH-1:0] PC_plus4,
    output logic                  misalign
);

    assign PC_plus4 = PC + ADDR_WIDTH'(4);
    assign misalign = PC_select && (PC_target[1:0] != 2'b00);

    // A misaligned target leaves the PC pointing at the offending instruction.
    always_ff @(posedge clock) begin
        if (reset) begin
            PC <= RESET_VECTOR;
        end else if (update && !misalign) begin
            PC <= PC_select ? PC_target : PC_plus4;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch front end: requests the word at PC, holds it for the controller,
// retires it on advance and traps misaligned branch/jump targets.
module instruction_fetch
    import cpu_defs::*;
#(
    parameter int                    ADDR_WIDTH   = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  PC_select,
    input  logic [ADDR_WIDTH-1:0] PC_target,
    input  logic                  advance,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic                  imem_ready,
    input  logic [31:0]           imem_rdata,
    output logic                  instr_valid,
    output logic [31:0]           instr,
    output logic [6:0]            opcode,
    output logic [2:0]            funct3,
    output logic                  funct7b5,
    output logic [ADDR_WIDTH-1:0] PC,
    output logic [ADDR_WIDTH-1:0] PC_plus4,
    output logic                  fetch_fault,
    output logic [31:0]           instret
);

    fetch_state_t state;
    logic         retire;
    logic         misalign;

    assign retire = (state == ST_HOLD) && advance;

    pc_register #(
        .ADDR_WIDTH   (ADDR_WIDTH),
        .RESET_VECTOR (RESET_VECTOR)
    ) u_pc_register (
        .clock     (clock),
        .reset     (reset),
        .update    (retire),
        .PC_select (PC_select),
        .PC_target (PC_target),
        .PC        (PC),
        .PC_plus4  (PC_plus4),
        .misalign  (misalign)
    );

    assign imem_addr = PC;
    assign opcode    = instr[OPCODE_MSB:OPCODE_LSB];
    assign funct3    = instr[FUNCT3_MSB:FUNCT3_LSB];
    assign funct7b5  = instr[FUNCT7B5_BIT];

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ST_FETCH;
            imem_req    <= 1'b1;
            instr_valid <= 1'b0;
            instr       <= NOP_INSTR;
            fetch_fault <= 1'b0;
            instret     <= 32'd0;
        end else begin
            case (state)
                ST_FETCH: begin
                    if (imem_ready) begin
                        instr       <= imem_rdata;
                        state       <= ST_HOLD;
                        imem_req    <= 1'b0;
                        instr_valid <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (advance) begin
                        instr_valid <= 1'b0;
                        if (misalign) begin
                            fetch_fault <= 1'b1;
                            state       <= ST_FAULT;
                        end else begin
                            instret  <= instret + 32'd1;
                            state    <= ST_FETCH;
                            imem_req <= 1'b1;
                        end
                    end
                end
                ST_FAULT: begin
                end
                // The spare encoding falls back to a fresh fetch.
                default: begin
                    state       <= ST_FETCH;
                    imem_req    <= 1'b1;
                    instr_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios plus randomized traffic
// checked against a transaction-level model of the fetch front end.
module tb_instruction_fetch;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        PC_select = 1'b0;
    logic [31:0] PC_target = 32'd0;
    logic        advance = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic [31:0] PC;
    logic [31:0] PC_plus4;
    logic        fetch_fault;
    logic [31:0] instret;

    int total = 0;
    int bad   = 0;

    // Reference model: 0 = waiting for memory, 1 = holding a word, 2 = trapped.
    int          m_mode    = 0;
    logic [31:0] m_pc      = 32'd0;
    logic [31:0] m_instret = 32'd0;
    logic [31:0] m_instr   = 32'h0000_0013;
    logic        m_fault   = 1'b0;

    always #5 clock = ~clock;

    instruction_fetch dut (
        .clock       (clock),
        .reset       (reset),
        .PC_select   (PC_select),
        .PC_target   (PC_target),
        .advance     (advance),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr       (instr),
        .opcode      (opcode),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .PC          (PC),
        .PC_plus4    (PC_plus4),
        .fetch_fault (fetch_fault),
        .instret     (instret)
    );

    // Drive one cycle of inputs, advance the model, and settle past the edge.
    task automatic tick(input logic rst, input logic rdy, input logic [31:0] rdata,
                        input logic adv, input logic sel, input logic [31:0] tgt);
        reset = rst; imem_ready = rdy; imem_rdata = rdata;
        advance = adv; PC_select = sel; PC_target = tgt;
        if (rst) begin
            m_mode = 0; m_pc = 32'd0; m_instret = 32'd0; m_instr = 32'h0000_0013; m_fault = 1'b0;
        end else if (m_mode == 0) begin
            if (rdy) begin m_instr = rdata; m_mode = 1; end
        end else if (m_mode == 1 && adv) begin
            if (sel && (tgt % 4 != 0)) begin
                m_fault = 1'b1; m_mode = 2;
            end else begin
                m_pc = sel ? tgt : m_pc + 32'd4;
                m_instret = m_instret + 32'd1;
                m_mode = 0;
            end
        end
        @(posedge clock);
        #1;
        reset = 1'b0; imem_ready = 1'b0; advance = 1'b0; PC_select = 1'b0;
    endtask

    // From a held word, jump to addr and load word there.
    task automatic goto(input logic [31:0] addr, input logic [31:0] word);
        tick(0, 0, 32'd0, 1, 1, addr);
        tick(0, 1, word, 0, 0, 32'd0);
    endtask

    task automatic test_reset;
        tick(1, 0, 32'd0, 0, 0, 32'd0);
        tick(1, 1, 32'hDEAD_BEEF, 1, 0, 32'd0);
        total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL reset_req got=%b exp=1", imem_req); end
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", instr_valid); end
        total++; if (instr !== 32'h0000_0013) begin bad++; $display("FAIL reset_instr got=%h exp=00000013", instr); end
        total++; if (PC !== 32'd0) begin bad++; $display("FAIL reset_pc got=%h exp=0", PC); end
        total++; if (fetch_fault !== 1'b0) begin bad++; $display("FAIL reset_fault got=%b exp=0", fetch_fault); end
        total++; if (instret !== 32'd0) begin bad++; $display("FAIL reset_instret got=%h exp=0", instret); end
    endtask

    task automatic test_zero_wait;
        total++; if (imem_addr !== 32'd0) begin bad++; $display("FAIL zw_addr got=%h exp=0", imem_addr); end
        tick(0, 1, 32'h0000_0093, 0, 0, 32'd0);
        total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL zw_valid got=%b exp=1", instr_valid); end
        total++; if (opcode !== 7'h13) begin bad++; $display("FAIL zw_opcode got=%h exp=13", opcode); end
        total++; if (instr !== 32'h0000_0093) begin bad++; $display("FAIL zw_instr got=%h exp=00000093", instr); end
        total++; if (PC !== 32'd0) begin bad++; $display("FAIL zw_pc got=%h exp=0", PC); end
        total++; if (PC_plus4 !== 32'd4) begin bad++; $display("FAIL zw_pc4 got=%h exp=4", PC_plus4); end
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL zw_req got=%b exp=0", imem_req); end
    endtask

    task automatic test_stall;
        logic [31:0] exp_ir;
        goto(32'h10, 32'h0000_0033);
        exp_ir = m_instret + 32'd1;
        tick(0, 0, 32'd0, 1, 0, 32'd0);
        total++; if (imem_addr !== 32'h14) begin bad++; $display("FAIL stall_addr got=%h exp=14", imem_addr); end
        total++; if (instret !== exp_ir) begin bad++; $display("FAIL stall_instret got=%h exp=%h", instret, exp_ir); end
        for (int i = 0; i < 4; i++) begin
            total++; if (imem_req !== 1'b1 || instr_valid !== 1'b0) begin
                bad++; $display("FAIL stall_wait%0d got=req%b/valid%b exp=req1/valid0", i, imem_req, instr_valid);
            end
            tick(0, (i == 3), 32'h0040_0513, 0, 0, 32'd0);
        end
        total++; if (instr_valid !== 1'b1 || PC !== 32'h14) begin
            bad++; $display("FAIL stall_done got=valid%b/pc%h exp=valid1/pc00000014", instr_valid, PC);
        end
    endtask

    task automatic test_branch;
        logic [31:0] word;
        goto(32'h20, 32'h0000_0063);
        tick(0, 0, 32'd0, 1, 1, 32'h100);
        total++; if (imem_addr !== 32'h100) begin bad++; $display("FAIL br_addr got=%h exp=100", imem_addr); end
        word = $urandom();
        tick(0, 1, word, 0, 0, 32'd0);
        total++; if (opcode !== word[6:0]) begin bad++; $display("FAIL br_opcode got=%h exp=%h", opcode, word[6:0]); end
        total++; if (funct3 !== word[14:12]) begin bad++; $display("FAIL br_funct3 got=%h exp=%h", funct3, word[14:12]); end
        total++; if (funct7b5 !== word[30]) begin bad++; $display("FAIL br_f7b5 got=%b exp=%b", funct7b5, word[30]); end
    endtask

    task automatic test_fault;
        logic [31:0] exp_ir;
        goto(32'h20, 32'h0000_0067);
        exp_ir = m_instret;
        tick(0, 0, 32'd0, 1, 1, 32'h102);
        total++; if (fetch_fault !== 1'b1) begin bad++; $display("FAIL flt_flag got=%b exp=1", fetch_fault); end
        total++; if (instret !== exp_ir) begin bad++; $display("FAIL flt_instret got=%h exp=%h", instret, exp_ir); end
        for (int i = 0; i < 6; i++) begin
            total++; if (imem_req !== 1'b0 || instr_valid !== 1'b0 || PC !== 32'h20) begin
                bad++; $display("FAIL flt_stuck%0d got=req%b/valid%b/pc%h exp=req0/valid0/pc00000020", i, imem_req, instr_valid, PC);
            end
            tick(0, 1'($urandom_range(1)), $urandom(), 1'($urandom_range(1)), 1'($urandom_range(1)), 32'h40);
        end
        tick(1, 0, 32'd0, 0, 0, 32'd0);
        total++; if (fetch_fault !== 1'b0) begin bad++; $display("FAIL flt_clear got=%b exp=0", fetch_fault); end
        total++; if (imem_addr !== 32'd0 || imem_req !== 1'b1) begin
            bad++; $display("FAIL flt_restart got=addr%h/req%b exp=addr00000000/req1", imem_addr, imem_req);
        end
    endtask

    task automatic test_wrap;
        tick(1, 0, 32'd0, 0, 0, 32'd0);
        tick(0, 1, 32'h0000_0013, 0, 0, 32'd0);
        goto(32'hFFFF_FFFC, 32'h0000_0013);
        total++; if (PC_plus4 !== 32'd0) begin bad++; $display("FAIL wrap_pc4 got=%h exp=0", PC_plus4); end
        tick(0, 0, 32'd0, 1, 0, 32'd0);
        total++; if (PC !== 32'd0 || fetch_fault !== 1'b0) begin
            bad++; $display("FAIL wrap_pc got=pc%h/fault%b exp=pc00000000/fault0", PC, fetch_fault);
        end
        tick(0, 1, 32'h0000_0013, 0, 0, 32'd0);
        force dut.instret = 32'hFFFF_FFFF;
        #1;
        release dut.instret;
        m_instret = 32'hFFFF_FFFF;
        tick(0, 0, 32'd0, 1, 0, 32'd0);
        total++; if (instret !== 32'd0) begin bad++; $display("FAIL wrap_instret got=%h exp=0", instret); end
    endtask

    task automatic test_reset_midfetch;
        tick(1, 0, 32'd0, 0, 0, 32'd0);
        tick(0, 1, 32'h0000_0013, 0, 0, 32'd0);
        tick(0, 0, 32'd0, 1, 1, 32'h80);
        tick(0, 0, 32'd0, 0, 0, 32'd0);
        tick(1, 1, 32'hCAFE_F00D, 0, 0, 32'd0);
        total++; if (instr !== 32'h0000_0013 || instr_valid !== 1'b0) begin
            bad++; $display("FAIL mid_instr got=%h/valid%b exp=00000013/valid0", instr, instr_valid);
        end
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'd0) begin
            bad++; $display("FAIL mid_req got=req%b/addr%h exp=req1/addr00000000", imem_req, imem_addr);
        end
        tick(0, 0, 32'd0, 1, 1, 32'h44);
        total++; if (PC !== 32'd0 || instret !== 32'd0 || imem_req !== 1'b1) begin
            bad++; $display("FAIL mid_adv got=pc%h/ir%h/req%b exp=pc00000000/ir00000000/req1", PC, instret, imem_req);
        end
    endtask

    task automatic test_random;
        logic [31:0] tgt;
        logic [31:0] word;
        tick(1, 0, 32'd0, 0, 0, 32'd0);
        for (int n = 0; n < 600; n++) begin
            tgt = $urandom() & 32'hFFFF_FFFC;
            if ($urandom_range(7) == 0) tgt = tgt | 32'($urandom_range(3, 1));
            word = $urandom();
            tick(($urandom_range(63) == 0), ($urandom_range(1) == 1), word,
                 ($urandom_range(4) < 2), ($urandom_range(1) == 1), tgt);
            total++; if (imem_req !== (m_mode == 0) || instr_valid !== (m_mode == 1)) begin
                bad++; $display("FAIL rnd_ctrl n=%0d got=req%b/valid%b exp=mode%0d", n, imem_req, instr_valid, m_mode);
            end
            total++; if (PC !== m_pc || imem_addr !== m_pc || PC_plus4 !== m_pc + 32'd4) begin
                bad++; $display("FAIL rnd_pc n=%0d got=%h/%h/%h exp=%h", n, PC, imem_addr, PC_plus4, m_pc);
            end
            total++; if (instret !== m_instret || fetch_fault !== m_fault) begin
                bad++; $display("FAIL rnd_cnt n=%0d got=ir%h/f%b exp=ir%h/f%b", n, instret, fetch_fault, m_instret, m_fault);
            end
            if (m_mode == 1) begin
                total++; if (instr !== m_instr || opcode !== m_instr[6:0] || funct3 !== m_instr[14:12]) begin
                    bad++; $display("FAIL rnd_instr n=%0d got=%h exp=%h", n, instr, m_instr);
                end
            end
        end
    endtask

    initial begin
        #1;
        test_reset;
        test_zero_wait;
        test_stall;
        test_branch;
        test_fault;
        test_wrap;
        test_reset_midfetch;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
